// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [63:0] PCRESET   = 64'h8000_0000;

    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return pc & ~64'd3;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} entries; flush wins over push/pop.
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  head_q, tail_q;
    logic [CW-1:0]  count_q;
    logic           do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage carries no reset; empty_o masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + 1'b1;
            if (do_pop)  head_q <= head_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: pc register and FETCH/HOLD/FLUSH control around a
// small instruction queue feeding decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = PCRESET,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [63:0] dec_pc
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t  state_q;
    logic [63:0]   pc_q;
    logic [63:0]   addr_q;
    logic          req_q;

    logic          resp, push, pop;
    logic          q_full, q_empty;
    logic [CW-1:0] q_count, count_after;
    fetch_entry_t  head;
    fetch_entry_t  new_entry;

    // A data_ok only counts while a request is actually on the bus.
    assign resp        = req_q && iresp_ok;
    assign pop         = !q_empty && dec_ready && !redirect_valid;
    assign push        = (state_q == FETCH) && resp && !redirect_valid && (!q_full || pop);
    assign count_after = q_count + CW'(push) - CW'(pop);
    assign new_entry   = '{pc: pc_q, instr: iresp_data};

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (new_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    // addr_q keeps the in-flight address through FLUSH so the bus sees a
    // stable request until its data_ok; pc_q already points at the target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else if (redirect_valid) begin
            pc_q <= align_pc(redirect_pc);
            if (req_q && !iresp_ok) begin
                state_q <= FLUSH;
                req_q   <= 1'b1;
            end else begin
                state_q <= FETCH;
                req_q   <= 1'b1;
                addr_q  <= align_pc(redirect_pc);
            end
        end else begin
            case (state_q)
                FETCH: begin
                    req_q <= 1'b1;
                    if (resp) begin
                        pc_q   <= pc_q + 64'd4;
                        addr_q <= pc_q + 64'd4;
                        if (count_after >= CW'(QUEUE_DEPTH)) begin
                            state_q <= HOLD;
                            req_q   <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (pop) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                FLUSH: begin
                    if (resp) begin
                        state_q <= FETCH;
                        addr_q  <= pc_q;
                    end
                end
                default: begin
                    state_q <= FETCH;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ireq_valid = req_q;
    assign ireq_addr  = addr_q;

    assign dec_valid  = !q_empty;
    assign dec_instr  = q_empty ? NOP_INSTR : head.instr;
    assign dec_pc     = q_empty ? 64'd0     : head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a transaction-level model predicts the
// decode stream and request addresses; a monitor compares them.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;

    fetch_stage #(.RESET_PC(RST_PC), .QUEUE_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_ok       (iresp_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { bit chk; logic [63:0] addr; } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    logic [63:0] mpc;
    bit          stale;
    int          n_cmp = 0;
    int          n_err = 0;

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] word_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h0BAD_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        bus_q.delete();
        mpc   = RST_PC;
        stale = 1'b0;
    endtask

    // One cycle of stimulus plus the model update for that cycle.
    task automatic step(input bit rsp, input bit rdy, input bit rd, input logic [63:0] rpc);
        bus_t b;
        exp_t e;
        @(negedge clk);
        iresp_ok       = rsp && ireq_valid;
        iresp_data     = iresp_ok ? word_of(ireq_addr) : $urandom;
        dec_ready      = rdy;
        redirect_valid = rd;
        redirect_pc    = rpc;
        if (iresp_ok) begin
            b.chk  = !stale;
            b.addr = mpc;
            bus_q.push_back(b);
        end
        if (rd) begin
            exp_q.delete();
            stale = ireq_valid && !iresp_ok;
            mpc   = rpc & ~64'd3;
        end else if (iresp_ok) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                e.pc    = mpc;
                e.instr = word_of(mpc);
                exp_q.push_back(e);
                mpc = mpc + 64'd4;
            end
        end
    endtask

    // Monitor: retire bus responses and decode handshakes against the model.
    initial begin
        bus_t b;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (iresp_ok) begin
                if (bus_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL bus_resp: response with no expectation at %0t", $time);
                end else begin
                    b = bus_q.pop_front();
                    if (b.chk) chk("ireq_addr", ireq_addr, b.addr);
                end
            end
            if (dec_valid && dec_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL dec_extra: got pc %h, expected no entry at %0t", dec_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("dec_pc", dec_pc, e.pc);
                    chk("dec_instr", {32'h0, dec_instr}, {32'h0, e.instr});
                end
            end
        end
    end

    initial begin
        logic [63:0] hpc;
        model_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_ireq_valid", {63'h0, ireq_valid}, 64'd0);
        chk("rst_dec_valid",  {63'h0, dec_valid},  64'd0);
        chk("rst_dec_instr",  {32'h0, dec_instr},  {32'h0, NOP_INSTR});
        chk("rst_dec_pc",     dec_pc,              64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Responses every second cycle, decoder always ready.
        for (int i = 0; i < 14; i++) step(i[0], 1'b1, 1'b0, '0);

        // Decoder stalls: queue fills and fetching stops.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        chk("hold_ireq_valid", {63'h0, ireq_valid}, 64'd0);
        chk("hold_dec_valid",  {63'h0, dec_valid},  64'd1);
        hpc = (exp_q.size() != 0) ? exp_q[0].pc : 64'd0;
        chk("hold_head_pc", dec_pc, hpc);
        step(1'b0, 1'b1, 1'b0, '0);
        @(posedge clk); #1;
        chk("resume_ireq_valid", {63'h0, ireq_valid}, 64'd1);
        chk("resume_addr", ireq_addr, hpc + 64'd8);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);

        // Redirect with a fetch in flight; stale word arrives 3 cycles later.
        step(1'b0, 1'b1, 1'b1, 64'h8000_1000);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        @(posedge clk); #1;
        chk("flush_ireq_valid", {63'h0, ireq_valid}, 64'd1);
        chk("flush_next_addr",  ireq_addr, 64'h8000_1000);
        chk("flush_dec_valid",  {63'h0, dec_valid}, 64'd0);
        for (int i = 0; i < 8; i++) step(i[0], 1'b1, 1'b0, '0);

        // Redirect coincident with a response.
        step(1'b1, 1'b1, 1'b1, 64'h8000_2000);
        @(posedge clk); #1;
        chk("coinc_dec_valid", {63'h0, dec_valid}, 64'd0);
        chk("coinc_next_addr", ireq_addr, 64'h8000_2000);

        // Misaligned redirect target.
        step(1'b1, 1'b1, 1'b1, 64'h8000_0203);
        @(posedge clk); #1;
        chk("align_addr", ireq_addr, 64'h8000_0200);
        for (int i = 0; i < 6; i++) step(i[0], 1'b1, 1'b0, '0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 24) == 0,
                 {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)});
        end

        // Reset in the middle of activity with a full queue.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0);
        #2;
        reset          = 1'b0;
        iresp_ok       = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("midrst_dec_valid",  {63'h0, dec_valid},  64'd0);
        chk("midrst_ireq_valid", {63'h0, ireq_valid}, 64'd0);
        chk("midrst_dec_instr",  {32'h0, dec_instr},  {32'h0, NOP_INSTR});
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rel_ireq_valid", {63'h0, ireq_valid}, 64'd1);
        chk("rel_addr", ireq_addr, RST_PC);
        for (int i = 0; i < 12; i++) step(i[0], 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
